// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// FSM state encoding, port identifiers and the default timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_ERR   = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/arb_timeout_ctr.sv
// 8-bit watchdog for a granted memory op; o_tc flags the cycle on which the
// count would reach TIMEOUT, so the FSM can leave on that same edge.
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= 8'd0;
    end else if (i_clr) begin
      r_count <= 8'd0;
    end else if (i_en) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_tc = i_en && (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one stalling single-ported memory between the fetch and memory
// stages. Optional feature: define ARB_ROUND_ROBIN_EN for round-robin on contention.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_stall,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic              d_dump,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  output logic              m_rd,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_dump,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  input  logic              m_err,
  output logic              err
);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_err;
  logic       w_d_req;
  logic       w_pick_d;
  logic       w_in_gnt;
  logic       w_tc;

  assign w_d_req  = d_rd | d_wr;
  assign w_in_gnt = (r_state == ST_GNT_I) || (r_state == ST_GNT_D);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // On contention the port that lost the previous grant goes first.
  assign w_pick_d = w_d_req & (~i_req | (r_last_grant == PORT_I));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_grant <= PORT_I;
    end else if ((r_state == ST_IDLE) && (w_d_req || i_req)) begin
      r_last_grant <= w_pick_d ? PORT_D : PORT_I;
    end
  end
`else
  assign w_pick_d = w_d_req;
`endif

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst   (rst),
    .i_clr (~w_in_gnt),
    .i_en  (w_in_gnt & ~m_done),
    .o_tc  (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_d) begin
          w_state_next = ST_GNT_D;
        end else if (i_req) begin
          w_state_next = ST_GNT_I;
        end
      end
      // m_done takes precedence over a coincident terminal count.
      ST_GNT_I, ST_GNT_D: begin
        if (m_done) begin
          w_state_next = ST_IDLE;
        end else if (w_tc) begin
          w_state_next = ST_ERR;
        end
      end
      ST_ERR:  w_state_next = ST_ERR;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    i_rdata = '0;
    d_rdata = '0;
    i_done  = 1'b0;
    d_done  = 1'b0;
    case (r_state)
      ST_GNT_I: begin
        m_rd    = 1'b1;
        m_addr  = i_addr;
        i_rdata = m_rdata;
        i_done  = m_done & rst;
      end
      ST_GNT_D: begin
        m_rd    = d_rd;
        m_wr    = d_wr;
        m_addr  = d_addr;
        m_wdata = d_wdata;
        d_rdata = m_rdata;
        d_done  = m_done & rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (m_err || ((w_state_next == ST_ERR) && (r_state != ST_ERR))) begin
      r_err <= 1'b1;
    end
  end

  assign err     = r_err;
  assign m_dump  = d_dump;
  assign i_stall = i_req & ~i_done;
  assign d_stall = w_d_req & ~d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=4); the memory is driven by
// hand cycle by cycle so every latency is explicit in the stimulus.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_dump;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        m_rd;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_dump;
  logic [15:0] m_rdata;
  logic        m_done;
  logic        m_err;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_done  (i_done),
    .i_stall (i_stall),
    .d_rd    (d_rd),
    .d_wr    (d_wr),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_dump  (d_dump),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_stall (d_stall),
    .m_rd    (m_rd),
    .m_wr    (m_wr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_dump  (m_dump),
    .m_rdata (m_rdata),
    .m_done  (m_done),
    .m_err   (m_err),
    .err     (err)
  );

  // Inputs change 1 ns after the edge; outputs are sampled 4 ns after it.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 1'b0; i_addr = '0; d_rd = 1'b0; d_wr = 1'b0;
    d_addr = '0; d_wdata = '0; d_dump = 1'b0; m_rdata = '0; m_done = 1'b0; m_err = 1'b0;
    next_cycle();
    i_req = 1'b1;
    d_dump = 1'b1;
    next_cycle();
    sample();
    n_vec++; if ({m_rd, m_wr, i_done, d_done, err} !== 5'b0) begin n_err++; $display("FAIL reset_outputs: got %b want 00000", {m_rd, m_wr, i_done, d_done, err}); end
    n_vec++; if (i_stall !== 1'b1) begin n_err++; $display("FAIL reset_i_stall: got %b want 1", i_stall); end
    n_vec++; if (m_dump !== 1'b1) begin n_err++; $display("FAIL reset_m_dump: got %b want 1", m_dump); end
    next_cycle();
    rst = 1'b1; i_req = 1'b0; d_dump = 1'b0;
    sample();
    n_vec++; if ({m_rd, m_wr, err, m_dump} !== 4'b0) begin n_err++; $display("FAIL reset_release: got %b want 0000", {m_rd, m_wr, err, m_dump}); end
    $display("reset: applied and released");
  endtask

  // L=3 load; m_done coincides with the timeout terminal count (TIMEOUT=4),
  // then a minimum-latency fetch is issued from the IDLE at cycle 5.
  task automatic test_lone_load();
    next_cycle();
    d_rd = 1'b1; d_addr = 16'h0040;
    sample();
    n_vec++; if ({m_rd, d_stall} !== 2'b01) begin n_err++; $display("FAIL load_c0: got m_rd,d_stall=%b want 01", {m_rd, d_stall}); end
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      sample();
      n_vec++; if ({m_rd, m_wr, d_done} !== 3'b100 || m_addr !== 16'h0040) begin n_err++; $display("FAIL load_c%0d: got m_rd,m_wr,d_done=%b m_addr=%h want 100 0040", c, {m_rd, m_wr, d_done}, m_addr); end
    end
    next_cycle();
    m_done = 1'b1; m_rdata = 16'hBEEF;
    sample();
    n_vec++; if ({m_rd, d_done, d_stall} !== 3'b110 || d_rdata !== 16'hBEEF) begin n_err++; $display("FAIL load_c4_done: got m_rd,d_done,d_stall=%b d_rdata=%h want 110 BEEF", {m_rd, d_done, d_stall}, d_rdata); end
    next_cycle();
    m_done = 1'b0; d_rd = 1'b0; i_req = 1'b1; i_addr = 16'h0080;
    sample();
    n_vec++; if ({m_rd, d_done, err} !== 3'b000) begin n_err++; $display("FAIL load_c5_idle: got m_rd,d_done,err=%b want 000", {m_rd, d_done, err}); end
    next_cycle();
    m_done = 1'b1; m_rdata = 16'hCAFE;
    sample();
    n_vec++; if ({m_rd, i_done, i_stall} !== 3'b110 || m_addr !== 16'h0080 || i_rdata !== 16'hCAFE) begin n_err++; $display("FAIL fetch_c6: got m_rd,i_done,i_stall=%b m_addr=%h i_rdata=%h want 110 0080 CAFE", {m_rd, i_done, i_stall}, m_addr, i_rdata); end
    next_cycle();
    m_done = 1'b0; i_req = 1'b0;
    sample();
    n_vec++; if ({m_rd, i_done, err} !== 3'b000) begin n_err++; $display("FAIL fetch_c7: got m_rd,i_done,err=%b want 000", {m_rd, i_done, err}); end
    $display("lone load 0040 -> BEEF, then fetch 0080 -> CAFE");
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_contention_fixed();
    next_cycle();
    i_req = 1'b1; i_addr = 16'h0100; d_wr = 1'b1; d_addr = 16'h0010; d_wdata = 16'h1234;
    sample();
    n_vec++; if ({m_rd, m_wr, i_stall, d_stall} !== 4'b0011) begin n_err++; $display("FAIL fixed_c0: got %b want 0011", {m_rd, m_wr, i_stall, d_stall}); end
    next_cycle();
    sample();
    n_vec++; if ({m_rd, m_wr, i_stall, d_done} !== 4'b0110 || m_addr !== 16'h0010 || m_wdata !== 16'h1234) begin n_err++; $display("FAIL fixed_c1_store: got %b addr=%h wdata=%h want 0110 0010 1234", {m_rd, m_wr, i_stall, d_done}, m_addr, m_wdata); end
    next_cycle();
    m_done = 1'b1; m_rdata = 16'hDEAD;
    sample();
    n_vec++; if ({d_done, i_done, i_stall, d_stall} !== 4'b1010) begin n_err++; $display("FAIL fixed_c2_ddone: got %b want 1010", {d_done, i_done, i_stall, d_stall}); end
    next_cycle();
    m_done = 1'b0; d_wr = 1'b0;
    sample();
    n_vec++; if ({m_rd, m_wr, i_stall} !== 3'b001) begin n_err++; $display("FAIL fixed_c3_idle: got %b want 001", {m_rd, m_wr, i_stall}); end
    next_cycle();
    m_done = 1'b1; m_rdata = 16'h5A5A;
    sample();
    n_vec++; if ({m_rd, i_done, d_done, i_stall} !== 4'b1100 || m_addr !== 16'h0100 || i_rdata !== 16'h5A5A) begin n_err++; $display("FAIL fixed_c4_fetch: got %b addr=%h rdata=%h want 1100 0100 5A5A", {m_rd, i_done, d_done, i_stall}, m_addr, i_rdata); end
    next_cycle();
    m_done = 1'b0; i_req = 1'b0;
    sample();
    n_vec++; if ({m_rd, m_wr} !== 2'b00) begin n_err++; $display("FAIL fixed_c5: got %b want 00", {m_rd, m_wr}); end
    $display("contention fixed: store 0010<=1234 first, then fetch 0100");
  endtask
`else
  task automatic test_contention_rr();
    logic [15:0] want_addr;
    logic [1:0]  want_done;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    for (int r = 0; r < 3; r++) begin
      next_cycle();
      i_req = 1'b1; i_addr = 16'h0100; d_rd = 1'b1; d_addr = 16'h0200;
      next_cycle();
      m_done = 1'b1; m_rdata = 16'h1111;
      sample();
      want_addr = (r == 1) ? 16'h0100 : 16'h0200;
      want_done = (r == 1) ? 2'b10 : 2'b01;
      n_vec++; if (m_addr !== want_addr || {i_done, d_done} !== want_done) begin n_err++; $display("FAIL rr_round%0d: got addr=%h i/d_done=%b want %h %b", r, m_addr, {i_done, d_done}, want_addr, want_done); end
      next_cycle();
      m_done = 1'b0; i_req = 1'b0; d_rd = 1'b0;
      $display("round robin round %0d: granted addr %h", r, m_addr);
    end
  endtask
`endif

  task automatic test_reset_mid_op();
    next_cycle();
    d_rd = 1'b1; d_addr = 16'h0200;
    next_cycle();
    sample();
    n_vec++; if (m_rd !== 1'b1 || m_addr !== 16'h0200) begin n_err++; $display("FAIL abort_c1: got m_rd=%b addr=%h want 1 0200", m_rd, m_addr); end
    next_cycle();
    rst = 1'b0; m_done = 1'b1; m_rdata = 16'h3333;
    sample();
    n_vec++; if ({m_rd, d_done} !== 2'b10) begin n_err++; $display("FAIL abort_c2: got m_rd,d_done=%b want 10", {m_rd, d_done}); end
    next_cycle();
    rst = 1'b1; m_done = 1'b0;
    sample();
    n_vec++; if ({m_rd, d_done, err} !== 3'b000) begin n_err++; $display("FAIL abort_c3: got m_rd,d_done,err=%b want 000", {m_rd, d_done, err}); end
    next_cycle();
    m_done = 1'b1; m_rdata = 16'h7777;
    sample();
    n_vec++; if ({m_rd, d_done} !== 2'b11 || d_rdata !== 16'h7777) begin n_err++; $display("FAIL abort_c4_regrant: got m_rd,d_done=%b rdata=%h want 11 7777", {m_rd, d_done}, d_rdata); end
    next_cycle();
    m_done = 1'b0; d_rd = 1'b0;
    $display("reset mid-op: load 0200 aborted and reissued");
  endtask

  task automatic test_m_err_idle();
    next_cycle();
    m_err = 1'b1;
    sample();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL merr_c0: got err=%b want 0", err); end
    next_cycle();
    m_err = 1'b0;
    sample();
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL merr_c1: got err=%b want 1", err); end
    next_cycle();
    next_cycle();
    sample();
    n_vec++; if ({err, m_rd} !== 2'b10) begin n_err++; $display("FAIL merr_sticky: got err,m_rd=%b want 10", {err, m_rd}); end
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    sample();
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL merr_cleared: got err=%b want 0", err); end
    $display("m_err pulse in idle: err set and cleared by reset");
  endtask

  task automatic test_timeout();
    next_cycle();
    d_rd = 1'b1; d_addr = 16'h0300;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      sample();
      n_vec++; if ({m_rd, err} !== 2'b10) begin n_err++; $display("FAIL tmo_c%0d: got m_rd,err=%b want 10", c, {m_rd, err}); end
    end
    next_cycle();
    sample();
    n_vec++; if ({m_rd, err, d_done, d_stall} !== 4'b0101) begin n_err++; $display("FAIL tmo_c5_err: got %b want 0101", {m_rd, err, d_done, d_stall}); end
    next_cycle();
    i_req = 1'b1; i_addr = 16'h0400; m_done = 1'b1;
    sample();
    n_vec++; if ({m_rd, i_done, d_done, err} !== 4'b0001) begin n_err++; $display("FAIL tmo_c6_hold: got %b want 0001", {m_rd, i_done, d_done, err}); end
    next_cycle();
    m_done = 1'b0;
    sample();
    n_vec++; if ({m_rd, m_wr, m_addr, err} !== {2'b00, 16'h0000, 1'b1}) begin n_err++; $display("FAIL tmo_c7_stay: got m_rd,m_wr=%b addr=%h err=%b want 00 0000 1", {m_rd, m_wr}, m_addr, err); end
    rst = 1'b0; i_req = 1'b0; d_rd = 1'b0;
    next_cycle();
    rst = 1'b1;
    sample();
    n_vec++; if ({err, m_rd} !== 2'b00) begin n_err++; $display("FAIL tmo_cleared: got err,m_rd=%b want 00", {err, m_rd}); end
    $display("timeout on load 0300: ERR entered and cleared by reset");
  endtask

  initial begin
    test_reset();
    test_lone_load();
`ifndef ARB_ROUND_ROBIN_EN
    test_contention_fixed();
`else
    test_contention_rr();
`endif
    test_reset_mid_op();
    test_m_err_idle();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 ns want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences one shared, multi-cycle, single-ported memory between the fetch stage's instruction port and the memory stage's data port. Registers a grant, drives the memory with a held request until the memory reports done, then returns read data and a one-cycle done pulse to the winner. It sits between the fetch/memory pipeline stages and the stalling unified memory. It produces the per-port stall signals the hazard logic uses to freeze the pipeline.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- TIMEOUT, 64, cycles a granted op may wait for m_done before err is raised (legal range 2..255)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (asserted when 0)
- i_req  in  1  instruction read request; held until i_done
- i_addr  in  ADDR_W  instruction address; stable while i_req
- i_rdata  out  DATA_W  instruction read data; valid only when i_done
- i_done  out  1  one-cycle completion pulse for the instruction port
- i_stall  out  1  i_req & ~i_done
- d_rd, d_wr  in  1 each  data read/write request (mutually exclusive); held until d_done
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_dump  in  1  dump request, forwarded unmodified to m_dump
- d_rdata  out  DATA_W  load data; valid only when d_done
- d_done  out  1  one-cycle completion pulse for the data port
- d_stall  out  1  (d_rd|d_wr) & ~d_done
- m_rd, m_wr  out  1 each  memory command; held for the whole granted op
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_dump  out  1  = d_dump
- m_rdata  in  DATA_W  memory read data; valid with m_done
- m_done  in  1  memory completion
- m_err  in  1  memory error
- err  out  1  sticky error

## Operation
- States: IDLE, GNT_I, GNT_D, ERR.
- IDLE: no memory command. If a data request is present, next state is GNT_D. Else, if i_req is present, next state is GNT_I. Contention rules are in Configuration.
- GNT_x: m_rd/m_wr/m_addr/m_wdata are driven combinationally from the granted port's live inputs. The non-granted port sees done=0 and stall=1 if requesting.
- On m_done in GNT_x: x_done=1 and x_rdata=m_rdata in the same cycle. Next state is IDLE. No back-to-back grant from GNT.
- Timeout counter: cleared on entry to GNT_x, increments each GNT cycle without m_done. On reaching TIMEOUT, go to ERR.
- ERR: all m_* commands are 0 and both done outputs are 0. Stays in ERR until rst.
- err = sticky OR of (entry to ERR) and (m_err seen in any state). err is cleared only by rst.
- A write on the data port also produces d_done; d_rdata is don't-care for a write.
- If a requester drops its request mid-grant, the op still completes and the done pulse is still issued. Requesters must not do this.

## Timing
- Reset values: state IDLE, err 0, counter 0, last-grant = I, all m_* commands 0, i_done/d_done 0, stalls follow their combinational definitions.
- A request seen in IDLE at cycle 0 gives GNT with the command driven at cycle 1. With memory latency L (m_done at cycle 1+L), done is at 1+L and IDLE at 2+L.
- Minimum request-to-done latency is 2 cycles (L=1).
- A new request sampled in IDLE at 2+L is granted at 3+L.
- Simultaneous m_done and timeout terminal count: m_done wins (completion, no error).
- rst low mid-grant aborts the op. The command drops at the next edge and no done pulse is issued.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on contention in IDLE, grant the port that did not win the previous grant. A last-grant register updates on each grant.
- ARB_ROUND_ROBIN_EN undefined: on contention the data port always wins (fixed priority, oldest instruction first). The last-grant register is not built.

## Structure
- Shared package mem_arb_pkg holds:
  - state encoding constants for IDLE, GNT_I, GNT_D, ERR
  - port-ID constants PORT_I and PORT_D
  - the default TIMEOUT
- One sub-module, arb_timeout_ctr: 8-bit counter with clear, enable and terminal-count output at TIMEOUT.

## Test plan
- Lone load: d_rd, d_addr=0x0040, memory L=3 returns 0xBEEF -> m_rd held cycles 1-4, d_done and d_rdata=0xBEEF at cycle 4, IDLE at 5.
- Contention, fixed priority (macro off): i_req and d_wr (addr 0x0010, data 0x1234) both at cycle 0 -> data granted first, i_stall high throughout. Instruction is granted in the IDLE after d_done.
- Contention, round robin (macro on): three consecutive dual-request rounds -> grant order D, I, D.
- Timeout: TIMEOUT=4, m_done held 0 -> ERR after 4 GNT cycles, err=1, m_rd=0, err stays 1 until rst.
- m_done on terminal-count cycle -> normal done, err stays 0. Separately, m_err pulse in IDLE -> err=1 sticky.
- Reset mid-op: rst=0 at cycle 2 of an L=5 read -> m_rd=0 next cycle, no d_done, state IDLE, err=0.
